vending_machine: RTL and testbench



---
 rtl/vending_pkg.sv | 40 ++++
 rtl/vending_machine.sv | 76 +++++++
 tb/tb_vending_machine.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared types, encodings and unit-conversion helpers for the vending machine controller.
// All monetary amounts are expressed in Rs.5 units.
package vending_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [1:0] CHOICE_RS5  = 2'b00;
    localparam logic [1:0] CHOICE_RS10 = 2'b01;
    localparam logic [1:0] CHOICE_RS15 = 2'b10;
    localparam logic [1:0] CHOICE_RS20 = 2'b11;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_RS5  = 2'b01;
    localparam logic [1:0] COIN_RS10 = 2'b10;
    localparam logic [1:0] COIN_RS20 = 2'b11;

    localparam logic [1:0] CHNG_NONE = 2'b00;
    localparam logic [1:0] CHNG_RS5  = 2'b01;
    localparam logic [1:0] CHNG_RS10 = 2'b10;
    localparam logic [1:0] CHNG_RS15 = 2'b11;

    function automatic logic [2:0] price_units(input logic [1:0] choice);
        return {1'b0, choice} + 3'd1;
    endfunction

    function automatic logic [2:0] coin_units(input logic [1:0] in_mny);
        logic [2:0] units;
        case (in_mny)
            COIN_RS5:  units = 3'd1;
            COIN_RS10: units = 3'd2;
            COIN_RS20: units = 3'd4;
            default:   units = 3'd0;
        endcase
        return units;
    endfunction

endpackage

// File: rtl/vending_machine.sv
// Vending machine controller: accumulates coin credit and emits a one-cycle
// registered product/change pulse once the credit covers the latched item price.
module vending_machine
    import vending_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] choice,
    input  logic [1:0] in_mny,
    output logic [2:0] prd,
    output logic [1:0] chng
);

    // Initialisers equal the reset values so an unreset machine starts clean.
    state_t     state          = IDLE;
    logic [2:0] credit         = 3'd0;
    logic [1:0] latched_choice = CHOICE_RS5;
    logic [2:0] prd_q          = 3'd0;
    logic [1:0] chng_q         = CHNG_NONE;

    state_t     next_state;
    logic [2:0] next_credit;
    logic [1:0] next_choice;
    logic [2:0] next_prd;
    logic [1:0] next_chng;
    logic [1:0] active_choice;
    logic [2:0] sum;
    logic [2:0] price;
    logic [2:0] change_units;

    // A fresh transaction takes the live choice; once collecting, the latched one governs.
    always_comb begin
        next_state    = state;
        next_credit   = credit;
        next_choice   = latched_choice;
        next_prd      = 3'd0;
        next_chng     = CHNG_NONE;
        active_choice = (state == IDLE) ? choice : latched_choice;
        sum           = ((state == IDLE) ? 3'd0 : credit) + coin_units(in_mny);
        price         = price_units(active_choice);
        change_units  = sum - price;

        if (in_mny != COIN_NONE) begin
            next_choice = active_choice;
            if (sum >= price) begin
                next_prd    = {1'b1, active_choice};
                next_chng   = change_units[1:0];
                next_credit = 3'd0;
                next_state  = IDLE;
            end else begin
                next_credit = sum;
                next_state  = COLLECT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            credit         <= 3'd0;
            latched_choice <= CHOICE_RS5;
            prd_q          <= 3'd0;
            chng_q         <= CHNG_NONE;
        end else begin
            state          <= next_state;
            credit         <= next_credit;
            latched_choice <= next_choice;
            prd_q          <= next_prd;
            chng_q         <= next_chng;
        end
    end

    assign prd  = prd_q;
    assign chng = chng_q;

endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench for vending_machine: directed scenarios with literal
// expectations, then randomized coins checked every cycle against a rupee-level model.
module tb_vending_machine;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] choice = 2'b10;
    logic [1:0] in_mny = 2'b00;
    logic [2:0] prd;
    logic [1:0] chng;

    int checks   = 0;
    int failures = 0;

    vending_machine dut (
        .clk    (clk),
        .rst    (rst),
        .choice (choice),
        .in_mny (in_mny),
        .prd    (prd),
        .chng   (chng)
    );

    always #5 clk = ~clk;

    // Reference model in rupees: a transaction is open once any coin has been taken.
    int         coin_rs [4] = '{0, 5, 10, 20};
    int         credit_rs   = 0;
    int         model_item  = 0;
    bit         in_txn      = 1'b0;
    logic [2:0] exp_prd     = 3'd0;
    logic [1:0] exp_chng    = 2'd0;

    always @(posedge clk) begin
        int price_rs;
        exp_prd  = 3'd0;
        exp_chng = 2'd0;
        if (rst) begin
            credit_rs  = 0;
            model_item = 0;
            in_txn     = 1'b0;
        end else if (in_mny != 2'b00) begin
            if (!in_txn)
                model_item = int'(choice);
            credit_rs = credit_rs + coin_rs[in_mny];
            price_rs  = (model_item + 1) * 5;
            if (credit_rs >= price_rs) begin
                exp_prd   = 3'(4 + model_item);
                exp_chng  = 2'((credit_rs - price_rs) / 5);
                credit_rs = 0;
                in_txn    = 1'b0;
            end else begin
                in_txn = 1'b1;
            end
        end
    end

    // Every cycle, halfway between edges, the outputs must match the model.
    always @(negedge clk) begin
        checks++;
        if (prd !== exp_prd || chng !== exp_chng) begin
            failures++;
            $display("[TB] FAIL cycle_compare t=%0t prd=%b chng=%b expected prd=%b chng=%b",
                     $time, prd, chng, exp_prd, exp_chng);
        end
    end

    task automatic applyStimulus(input logic r, input logic [1:0] c, input logic [1:0] m);
        @(negedge clk);
        rst    = r;
        choice = c;
        in_mny = m;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] want_prd, input logic [1:0] want_chng);
        @(posedge clk);
        #1;
        checks++;
        if (prd !== want_prd || chng !== want_chng) begin
            failures++;
            $display("[TB] FAIL %s prd=%b chng=%b expected prd=%b chng=%b",
                     name, prd, chng, want_prd, want_chng);
        end
        checks++;
        if (exp_prd !== want_prd || exp_chng !== want_chng) begin
            failures++;
            $display("[TB] FAIL %s_model prd=%b chng=%b expected prd=%b chng=%b",
                     name, exp_prd, exp_chng, want_prd, want_chng);
        end
    endtask

    initial begin
        // No reset before the first coin: outputs must be clean zero, then a Rs.15 item from Rs.20.
        applyStimulus(1'b0, 2'b10, 2'b00);
        checkOutput("powerup_idle", 3'b000, 2'b00);
        applyStimulus(1'b0, 2'b10, 2'b11);
        checkOutput("noreset_rs20", 3'b110, 2'b01);

        applyStimulus(1'b1, 2'b00, 2'b00);
        checkOutput("reset", 3'b000, 2'b00);

        // Rs.10 item paid as Rs.5 + Rs.10.
        applyStimulus(1'b0, 2'b01, 2'b01);
        checkOutput("rs10_first_coin", 3'b000, 2'b00);
        applyStimulus(1'b0, 2'b01, 2'b10);
        checkOutput("rs10_dispense", 3'b101, 2'b01);
        applyStimulus(1'b0, 2'b01, 2'b00);
        checkOutput("rs10_pulse_end", 3'b000, 2'b00);

        applyStimulus(1'b0, 2'b00, 2'b01);
        checkOutput("rs5_exact", 3'b100, 2'b00);

        // Rs.20 item, three Rs.5 then Rs.20: maximum change.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 2'b11, 2'b01);
            checkOutput("rs20_partial", 3'b000, 2'b00);
        end
        applyStimulus(1'b0, 2'b11, 2'b11);
        checkOutput("rs20_max_change", 3'b111, 2'b11);

        // Rs.15 item with idle gaps; the later choice change must be ignored.
        applyStimulus(1'b0, 2'b10, 2'b10);
        checkOutput("rs15_first", 3'b000, 2'b00);
        applyStimulus(1'b0, 2'b10, 2'b00);
        applyStimulus(1'b0, 2'b10, 2'b00);
        applyStimulus(1'b0, 2'b00, 2'b10);
        checkOutput("rs15_choice_held", 3'b110, 2'b01);

        // Reset mid-transaction discards credit; reset also wins over a coin.
        applyStimulus(1'b0, 2'b11, 2'b10);
        checkOutput("midtxn_coin", 3'b000, 2'b00);
        applyStimulus(1'b1, 2'b11, 2'b11);
        checkOutput("reset_over_coin", 3'b000, 2'b00);
        applyStimulus(1'b0, 2'b01, 2'b10);
        checkOutput("after_reset_rs10", 3'b101, 2'b00);

        // Randomized traffic, checked each cycle by the compare process.
        for (int i = 0; i < 600; i++) begin
            logic       r;
            logic [1:0] m;
            r = ($urandom_range(0, 40) == 0);
            m = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            applyStimulus(r, 2'($urandom_range(0, 3)), m);
        end
        applyStimulus(1'b0, 2'b00, 2'b00);
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
